// File: rtl/pmod_dac_serializer.sv
// ----------------------------------------------------------------------------
// pmod_dac_serializer
//
// Last stage of the DAC sine/BPSK transmit chain. Takes one pair of signed
// 12-bit samples, converts each to offset binary, and shifts both out MSB
// first as 16-bit frames to a dual DAC121S101 (PmodDA2) on JA7..JA10.
// Frame layout, MSB first: 2'b00 | PD_MODE[1:0] | data[11:0].
//
// Ports:
//   CLK           in   system clock, all logic on the rising edge
//   reset         in   synchronous, active-low reset
//   enable        in   1 = new sample pairs may be accepted
//   sample_a      in   signed 12-bit sample for DAC channel A
//   sample_b      in   signed 12-bit sample for DAC channel B
//   sample_valid  in   sample_a/sample_b valid this cycle
//   sample_ready  out  block can accept a sample pair this cycle
//   JA7           out  DAC SYNC, active-low frame strobe
//   JA8           out  DAC DINA, serial data for channel A
//   JA9           out  DAC DINB, serial data for channel B
//   JA10          out  DAC SCLK, DAC samples DIN on its falling edge
//   busy          out  high while a frame or the post-frame gap is running
//   frame_done    out  one-cycle pulse when a frame plus its gap completes
// ----------------------------------------------------------------------------
module pmod_dac_serializer #(
    parameter int         CLK_DIV = 2,
    parameter int         GAP_CYC = 4,
    parameter logic [1:0] PD_MODE = 2'b00
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] sample_a,
    input  logic [11:0] sample_b,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        JA7,
    output logic        JA8,
    output logic        JA9,
    output logic        JA10,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    // Counter widths never drop to zero so CLK_DIV=1 / GAP_CYC=1 still work.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       bit_cnt;
    logic [15:0]      shreg_a;
    logic [15:0]      shreg_b;
    logic [15:0]      frame_a;
    logic [15:0]      frame_b;
    logic             accept;

    // Inverting the sign bit turns two's complement into offset binary:
    // -2048 -> 0x000, 0 -> 0x800, +2047 -> 0xFFF.
    assign frame_a = {2'b00, PD_MODE, ~sample_a[11], sample_a[10:0]};
    assign frame_b = {2'b00, PD_MODE, ~sample_b[11], sample_b[10:0]};

    // Ready is combinational so an upstream source can hand over a new pair
    // in the very first idle cycle after the gap.
    assign sample_ready = reset & enable & (state == IDLE);
    assign accept       = sample_valid & sample_ready;

    // Frame sequencer. The shift registers hold the whole frame and bit_cnt
    // points at the bit currently on the data pins, so new data is only
    // ever presented at the edge where SCLK returns high; the DAC therefore
    // always sees stable data at its falling-edge sample point.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state      <= IDLE;
            JA7        <= 1'b1;
            JA8        <= 1'b0;
            JA9        <= 1'b0;
            JA10       <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            shreg_a    <= '0;
            shreg_b    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg_a <= frame_a;
                        shreg_b <= frame_b;
                        JA8     <= frame_a[15];
                        JA9     <= frame_b[15];
                        JA7     <= 1'b0;
                        JA10    <= 1'b1;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= 4'd15;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (JA10) begin
                            JA10 <= 1'b0;
                        end else if (bit_cnt == 4'd0) begin
                            // Low phase of the last bit is over: release SYNC.
                            JA10    <= 1'b1;
                            JA7     <= 1'b1;
                            JA8     <= 1'b0;
                            JA9     <= 1'b0;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            JA10    <= 1'b1;
                            JA8     <= shreg_a[bit_cnt - 4'd1];
                            JA9     <= shreg_b[bit_cnt - 4'd1];
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmod_dac_serializer.sv
// ----------------------------------------------------------------------------
// tb_pmod_dac_serializer
//
// Self-checking bench for pmod_dac_serializer (CLK_DIV=2, GAP_CYC=4,
// PD_MODE=00). A cycle-timeline model predicts when pairs are accepted and
// what every pin should show; frames are also captured on SCLK falling edges
// the way the DAC would see them and compared against the model's queue.
// ----------------------------------------------------------------------------
module tb_pmod_dac_serializer;

    localparam int         CLK_DIV  = 2;
    localparam int         GAP_CYC  = 4;
    localparam logic [1:0] PD_MODE  = 2'b00;
    localparam int         SHIFT_LEN = 32 * CLK_DIV;
    localparam int         BUSY_LEN  = SHIFT_LEN + GAP_CYC;

    logic        CLK = 1'b0;
    logic        reset;
    logic        enable;
    logic [11:0] sample_a;
    logic [11:0] sample_b;
    logic        sample_valid;
    logic        sample_ready;
    logic        JA7, JA8, JA9, JA10;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    pmod_dac_serializer #(
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC),
        .PD_MODE (PD_MODE)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .enable       (enable),
        .sample_a     (sample_a),
        .sample_b     (sample_b),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .JA7          (JA7),
        .JA8          (JA8),
        .JA9          (JA9),
        .JA10         (JA10),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 CLK = ~CLK;

    // Every comparison goes through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Wait for the next rising edge, then move off it before touching inputs.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic v,
                                 input logic [11:0] a, input logic [11:0] b);
        reset        = r;
        enable       = e;
        sample_valid = v;
        sample_a     = a;
        sample_b     = b;
    endtask

    // Timeline model: after an accept the block is unavailable for BUSY_LEN
    // cycles; SYNC is low for the first SHIFT_LEN of them.
    int          cooldown     = 0;
    logic [15:0] cur_a        = '0;
    logic [15:0] cur_b        = '0;
    logic        fd_exp       = 1'b0;
    logic        model_accept = 1'b0;
    logic        aborted      = 1'b0;
    logic [31:0] exp_q[$];

    always @(posedge CLK) begin
        int va;
        int vb;
        fd_exp       = 1'b0;
        model_accept = 1'b0;
        if (reset !== 1'b1) begin
            // All 16 falling edges already reached the DAC on the final edge.
            if (cooldown == GAP_CYC + 1)
                exp_q.push_back({cur_a, cur_b});
            else if (cooldown > GAP_CYC + 1)
                aborted = 1'b1;
            cooldown = 0;
        end else if (cooldown != 0) begin
            cooldown--;
            if (cooldown == GAP_CYC)
                exp_q.push_back({cur_a, cur_b});
            if (cooldown == 0)
                fd_exp = 1'b1;
        end else if (enable && sample_valid) begin
            va = int'($signed(sample_a));
            vb = int'($signed(sample_b));
            cur_a = {2'b00, PD_MODE, 12'(va + 2048)};
            cur_b = {2'b00, PD_MODE, 12'(vb + 2048)};
            cooldown = BUSY_LEN;
            model_accept = 1'b1;
        end
    end

    // DAC-side capture: shift DIN in on every SCLK falling edge while SYNC
    // is low; a frame counts only if all 16 bits arrived.
    int          nbits = 0;
    logic [15:0] sh_a  = '0;
    logic [15:0] sh_b  = '0;
    logic [31:0] cap_q[$];

    always @(negedge JA10) begin
        if (JA7 === 1'b0) begin
            sh_a = {sh_a[14:0], JA8};
            sh_b = {sh_b[14:0], JA9};
            nbits++;
        end
    end

    always @(posedge JA7) begin
        if (nbits == 16)
            cap_q.push_back({sh_a, sh_b});
        nbits = 0;
    end

    // Per-cycle pin checks against the model, sampled on the falling edge.
    logic        check_en   = 1'b0;
    int          low_cnt    = 0;
    logic [31:0] last_frame = '0;

    always @(negedge CLK) begin
        int k;
        int bidx;
        if (check_en) begin
            checkOutput("ready", {31'd0, sample_ready},
                        {31'd0, (reset === 1'b1) && (enable === 1'b1) && (cooldown == 0)});
            checkOutput("busy", {31'd0, busy}, {31'd0, cooldown != 0});
            checkOutput("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
            checkOutput("sync", {31'd0, JA7}, {31'd0, !(cooldown > GAP_CYC)});
            if (cooldown > GAP_CYC) begin
                k    = BUSY_LEN - cooldown;
                bidx = 15 - k / (2 * CLK_DIV);
                checkOutput("sclk", {31'd0, JA10}, {31'd0, ((k / CLK_DIV) % 2) == 0});
                checkOutput("dina", {31'd0, JA8}, {31'd0, cur_a[bidx]});
                checkOutput("dinb", {31'd0, JA9}, {31'd0, cur_b[bidx]});
            end else begin
                checkOutput("sclk_idle", {31'd0, JA10}, 32'd1);
                checkOutput("din_idle", {30'd0, JA8, JA9}, 32'd0);
            end
            if (JA7 === 1'b0) begin
                low_cnt++;
            end else if (low_cnt != 0) begin
                if (!aborted)
                    checkOutput("sync_len", low_cnt, SHIFT_LEN);
                low_cnt = 0;
                aborted = 1'b0;
            end
            while (cap_q.size() > 0 && exp_q.size() > 0) begin
                last_frame = cap_q.pop_front();
                checkOutput("frame", last_frame, exp_q.pop_front());
            end
        end
    end

    // One-cycle valid pulse; the samples are scrambled right after the
    // accept edge to show the frame in flight is unaffected.
    task automatic sendPair(input logic [11:0] a, input logic [11:0] b);
        applyStimulus(1'b1, 1'b1, 1'b1, a, b);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 12'($urandom), 12'($urandom));
    endtask

    logic [11:0] ramp;

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 12'd0);

        // Reset held low for five edges, then released with enable still low.
        tick();
        check_en = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        repeat (3) tick();
        enable = 1'b1;
        tick();

        // Zero and most-negative sample.
        sendPair(12'h000, 12'h800);
        repeat (75) tick();
        checkOutput("t2_frame", last_frame, 32'h0800_0000);

        // Most-positive sample and -1.
        sendPair(12'h7FF, 12'hFFF);
        repeat (75) tick();
        checkOutput("t3_frame", last_frame, 32'h0FFF_07FF);

        // Valid held high with a ramp that crosses the sign boundary.
        ramp = 12'h7FD;
        applyStimulus(1'b1, 1'b1, 1'b1, ramp, -ramp);
        repeat (BUSY_LEN * 6 + 3) begin
            tick();
            if (model_accept) begin
                ramp = ramp + 12'd1;
                sample_a = ramp;
                sample_b = -ramp;
            end
        end
        sample_valid = 1'b0;
        repeat (80) tick();

        // Reset pulse during bit 7, then a fresh frame.
        sendPair(12'h123, 12'hABC);
        repeat (33) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (5) tick();
        sendPair(12'h5A5, 12'h3C3);
        repeat (75) tick();
        checkOutput("t5_frame", last_frame, 32'h0DA5_0BC3);

        // Enable dropped during bit 3 with valid held high.
        sendPair(12'h400, 12'hC00);
        repeat (49) tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 12'h0AA, 12'hF55);
        repeat (30) tick();
        enable = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (75) tick();
        checkOutput("t6_frame", last_frame, 32'h08AA_0755);

        // Randomised traffic with occasional reset and enable drops.
        repeat (2500) begin
            tick();
            applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 9) != 0,
                          $urandom_range(0, 2) != 0, 12'($urandom), 12'($urandom));
        end

        // Drain and make sure nothing was lost or invented.
        applyStimulus(1'b1, 1'b1, 1'b0, 12'd0, 12'd0);
        repeat (100) tick();
        checkOutput("leftover", cap_q.size() + exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
